booth_wallace_mult_16bit: RTL and testbench
===========================================

# booth_wallace_mult_16bit

Signed 16×16 → 32-bit multiplier built from radix-4 Booth recoding, a Wallace-tree carry-save reduction and a final carry-propagate adder. The product is registered once at the output. It is a leaf arithmetic datapath block for DSP/ALU paths that need a one-cycle, full-precision signed product.

## Interface
- No parameters. Widths are fixed at 16-bit operands and a 32-bit product.
- `clk`  input  1  single clock; all state is updated on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `X`  input  16  multiplicand, two's complement.
- `Y`  input  16  multiplier, two's complement; it drives the Booth recoding.
- `Out`  output  32  registered product X×Y, two's complement.

## Operation
- Operands are signed two's complement. Out = sign-extended X × sign-extended Y, exact in 32 bits with no overflow.
- Booth recoding, radix-4:
  - For i = 0..7, examine the triplet {Y[2i+1], Y[2i], Y[2i-1]}, with Y[-1] = 0.
  - The triplet gives a digit in {−2, −1, 0, +1, +2}.
  - This produces 8 partial products.
- Each partial product is the digit × X, formed as 0, ±X or ±2X in 17 bits:
  - Negation is one's complement plus a "neg" bit.
  - The neg bit is injected at weight 2^(2i) in the tree.
- Sign extension uses the standard constant-correction or sign-inversion scheme. Each row is weighted by 2^(2i).
- Wallace tree:
  - Uses 3:2 full-adder compressors and half adders.
  - Reduces the 8 rows plus the neg bits to two 32-bit vectors (sum, carry).
  - Bits above position 31 are discarded.
- A 32-bit carry-propagate adder combines sum and carry. Its carry-out is discarded.
- Arithmetic is modulo 2^32. The signed product always fits, including (−32768)×(−32768) = 0x40000000.
- No handshake. A new operand pair may be applied every cycle.

## Timing
- The datapath from X/Y to the D-input of the Out register is combinational.
- Out is registered. The product of X/Y sampled at rising edge n appears on Out after edge n, so latency is 1 cycle and throughput is 1 product per cycle.
- Reset:
  - `rst` high forces Out = 0x00000000 immediately, independent of clk.
  - While `rst` is high, Out stays 0.
- Deassertion of `rst`: the first rising edge with rst low captures the product of the current X/Y.
- Reset mid-stream: the in-flight product is lost, Out = 0, and there is no recovery of the previous value.
- X/Y changing between edges has no effect on Out until the next edge.
- The whole combinational path must meet one clock period. No internal pipelining is allowed, because latency is fixed at 1.

## Structure
- Shared package holds:
  - `MULT_W` = 16 and `PROD_W` = 32.
  - The Booth digit encoding, as an enum of ZERO, POS1, POS2, NEG1 or NEG2.
- Natural sub-modules:
  - `booth_encoder`: triplet → {neg, one, two} select signals plus the 17-bit partial-product row.
  - `full_adder`: the 3:2 compressor cell replicated in the Wallace tree.
- The top level instantiates 8 encoders, the tree, the CPA and the output register.

## Test plan
- Apply rst = 1 asynchronously between clock edges with X = 0x7FFF, Y = 0x7FFF. Out must go to 0x00000000 immediately and stay 0 until the first edge after rst falls.
- Apply X = 0x094B (2379), Y = 0x016B (363). One edge later, Out must be 0x000D2D59 (863577).
- Check the sign corner cases:
  - X = 0xFFFF, Y = 0xFFFF → 0x00000001.
  - X = 0x8000, Y = 0x8000 → 0x40000000.
  - X = 0x8000, Y = 0x7FFF → 0xC0008000.
  - X = 0x7FFF, Y = 0x7FFF → 0x3FFF0001.
- Check zero operands: X = 0x0000, Y = 0x1234 → 0. X = 0xABCD, Y = 0x0000 → 0. X = 0x0001, Y = 0xFFFE → 0xFFFFFFFE.
- Back-to-back throughput: change X/Y on every cycle with 1000 random signed pairs. Out at cycle n+1 must equal the signed product of the pair applied at cycle n.
- Reset mid-stream: assert rst during the random stream. Out must be 0 while rst is high. The first edge after release must capture the product of the operands present at that edge.

Source files
------------

// File: rtl/booth_wallace_mult_16bit_pkg.sv
// rtl/booth_wallace_mult_16bit_pkg.sv - shared widths, Booth digit encoding and sign-correction constant
package booth_wallace_mult_16bit_pkg;

  localparam int MULT_W = 16;
  localparam int PROD_W = 32;
  localparam int NUM_PP = MULT_W / 2;

  // Radix-4 Booth digit selected by one recoding triplet
  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_digit_e;

  // Each row carries its sign bit inverted, which adds 2^(16+2i) per row
  // compared with true sign extension. The rows together add 0x55550000,
  // and this constant is its two's-complement negation modulo 2^32.
  localparam logic [PROD_W-1:0] SIGN_CORR = 32'hAAAB_0000;

endpackage

// File: rtl/booth_wallace_mult_16bit_if.sv
// rtl/booth_wallace_mult_16bit_if.sv - operand/product bundle for the multiplier
interface booth_wallace_mult_16bit_if;
  import booth_wallace_mult_16bit_pkg::*;

  logic [MULT_W-1:0] X;
  logic [MULT_W-1:0] Y;
  logic [PROD_W-1:0] Out;

  modport master (output X, output Y, input Out);
  modport slave  (input X, input Y, output Out);

endinterface

// File: rtl/booth_wallace_mult_16bit_booth_encoder.sv
// rtl/booth_wallace_mult_16bit_booth_encoder.sv - radix-4 Booth triplet decode and 17-bit partial product
module booth_encoder
  import booth_wallace_mult_16bit_pkg::*;
(
  input  logic [2:0]        trip_i,
  input  logic [MULT_W-1:0] x_i,
  output logic              neg_o,
  output logic [MULT_W:0]   pp_o
);

  booth_digit_e    digit;
  logic            one;
  logic            two;
  logic            neg;
  logic [MULT_W:0] mag;

  // Triplet {y[2i+1], y[2i], y[2i-1]} to signed digit; 111 is treated as +0
  always_comb begin
    digit = ZERO;
    case (trip_i)
      3'b000, 3'b111: digit = ZERO;
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      3'b101, 3'b110: digit = NEG1;
    endcase
  end

  // Select X or 2X, then one's-complement for negative digits; the +1 goes into the tree
  always_comb begin
    one   = (digit == POS1) || (digit == NEG1);
    two   = (digit == POS2) || (digit == NEG2);
    neg   = (digit == NEG1) || (digit == NEG2);
    mag   = '0;
    if (one) begin
      mag = {x_i[MULT_W-1], x_i};
    end else if (two) begin
      mag = {x_i, 1'b0};
    end
    pp_o  = neg ? ~mag : mag;
    neg_o = neg;
  end

endmodule

// File: rtl/booth_wallace_mult_16bit_csa.sv
// rtl/booth_wallace_mult_16bit_csa.sv - 32-bit carry-save row compressor (3 rows in, 2 rows out)
module carry_save_adder
  import booth_wallace_mult_16bit_pkg::*;
(
  input  logic [PROD_W-1:0] a_i,
  input  logic [PROD_W-1:0] b_i,
  input  logic [PROD_W-1:0] c_i,
  output logic [PROD_W-1:0] sum_o,
  output logic [PROD_W-1:0] carry_o
);

  logic [PROD_W-2:0] co;

  // Top column keeps only its sum; its carry would land above bit 31
  for (genvar b = 0; b < PROD_W; b++) begin : g_bit
    if (b < PROD_W - 1) begin : g_fa
      full_adder u_fa (
        .a_i     (a_i[b]),
        .b_i     (b_i[b]),
        .c_i     (c_i[b]),
        .sum_o   (sum_o[b]),
        .carry_o (co[b])
      );
    end else begin : g_top
      assign sum_o[b] = a_i[b] ^ b_i[b] ^ c_i[b];
    end
  end

  assign carry_o = {co, 1'b0};

endmodule

// File: rtl/booth_wallace_mult_16bit_full_adder.sv
// rtl/booth_wallace_mult_16bit_full_adder.sv - 3:2 compressor cell
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic sum_o,
  output logic carry_o
);

  assign sum_o   = a_i ^ b_i ^ c_i;
  assign carry_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/booth_wallace_mult_16bit.sv
// rtl/booth_wallace_mult_16bit.sv - signed 16x16 Booth/Wallace multiplier with registered product
module booth_wallace_mult_16bit
  import booth_wallace_mult_16bit_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  booth_wallace_mult_16bit_if.slave    mult
);

  logic [PROD_W-1:0] pp_row [NUM_PP];
  logic [NUM_PP-1:0] neg;
  logic [PROD_W-1:0] neg_vec;
  logic [PROD_W-1:0] s1a, c1a, s1b, c1b, s1c, c1c;
  logic [PROD_W-1:0] s2a, c2a, s2b, c2b;
  logic [PROD_W-1:0] s3, c3, s4, c4, s5, c5;
  logic [PROD_W-1:0] out_d;
  logic [PROD_W-1:0] out_q;

  // Eight encoders; each row has its sign bit inverted and is placed at weight 4^i
  for (genvar i = 0; i < NUM_PP; i++) begin : g_pp
    logic [2:0]      trip;
    logic [MULT_W:0] pp;

    if (i == 0) begin : g_first
      assign trip = {mult.Y[1:0], 1'b0};
    end else begin : g_rest
      assign trip = mult.Y[2*i+1 -: 3];
    end

    booth_encoder u_enc (
      .trip_i (trip),
      .x_i    (mult.X),
      .neg_o  (neg[i]),
      .pp_o   (pp)
    );

    assign pp_row[i] = {15'b0, ~pp[MULT_W], pp[MULT_W-1:0]} << (2 * i);
  end

  // Gather the negation +1 bits into one row at weights 2^(2i)
  always_comb begin
    neg_vec = '0;
    for (int i = 0; i < NUM_PP; i++) begin
      neg_vec[2*i] = neg[i];
    end
  end

  // Wallace reduction of 10 rows (8 partial products, neg row, sign correction) to 2
  carry_save_adder u_l1a (.a_i(pp_row[0]), .b_i(pp_row[1]), .c_i(pp_row[2]), .sum_o(s1a), .carry_o(c1a));
  carry_save_adder u_l1b (.a_i(pp_row[3]), .b_i(pp_row[4]), .c_i(pp_row[5]), .sum_o(s1b), .carry_o(c1b));
  carry_save_adder u_l1c (.a_i(pp_row[6]), .b_i(pp_row[7]), .c_i(neg_vec),   .sum_o(s1c), .carry_o(c1c));
  carry_save_adder u_l2a (.a_i(s1a), .b_i(c1a), .c_i(s1b),       .sum_o(s2a), .carry_o(c2a));
  carry_save_adder u_l2b (.a_i(c1b), .b_i(s1c), .c_i(c1c),       .sum_o(s2b), .carry_o(c2b));
  carry_save_adder u_l3  (.a_i(s2a), .b_i(c2a), .c_i(s2b),       .sum_o(s3),  .carry_o(c3));
  carry_save_adder u_l4  (.a_i(s3),  .b_i(c3),  .c_i(c2b),       .sum_o(s4),  .carry_o(c4));
  carry_save_adder u_l5  (.a_i(s4),  .b_i(c4),  .c_i(SIGN_CORR), .sum_o(s5),  .carry_o(c5));

  // Final carry-propagate add; carry-out falls off the 32-bit result
  always_comb begin
    out_d = s5 + c5;
  end

  // Product register, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign mult.Out = out_q;

endmodule

// File: tb/tb_booth_wallace_mult_16bit.sv
// tb/tb_booth_wallace_mult_16bit.sv - directed and streaming checks for the Booth/Wallace multiplier
module tb_booth_wallace_mult_16bit;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  booth_wallace_mult_16bit_if bus ();

  booth_wallace_mult_16bit dut (
    .clk  (clk),
    .rst  (rst),
    .mult (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive operands at a falling edge, check the product one falling edge later
  task automatic apply_check(input string tag, input logic [15:0] x, input logic [15:0] y,
                             input logic [31:0] exp);
    @(negedge clk);
    bus.X = x;
    bus.Y = y;
    @(negedge clk);
    check_eq(tag, bus.Out, exp);
  endtask

  function automatic logic [31:0] ref_prod(input logic [15:0] x, input logic [15:0] y);
    int xi;
    int yi;
    xi = {{16{x[15]}}, x};
    yi = {{16{y[15]}}, y};
    return 32'(xi * yi);
  endfunction

  initial begin
    logic [15:0] rx;
    logic [15:0] ry;
    logic [31:0] prev_exp;
    bit          prev_valid;

    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    bus.X   = 16'h7FFF;
    bus.Y   = 16'h7FFF;

    // Let a nonzero product settle, then reset asynchronously between edges
    repeat (2) @(negedge clk);
    check_eq("pre_reset_7fff_sq", bus.Out, 32'h3FFF_0001);
    #2 rst = 1'b1;
    #1 check_eq("async_reset", bus.Out, 32'h0000_0000);
    repeat (3) @(negedge clk);
    check_eq("reset_hold", bus.Out, 32'h0000_0000);

    // Release and capture the first product on the following edge
    bus.X = 16'h094B;
    bus.Y = 16'h016B;
    rst   = 1'b0;
    @(negedge clk);
    check_eq("first_after_release", bus.Out, 32'h000D_2D59);

    // Operand changes between edges do not reach Out
    bus.X = 16'h0005;
    bus.Y = 16'h0007;
    #2 check_eq("hold_between_edges", bus.Out, 32'h000D_2D59);
    @(negedge clk);
    check_eq("small_5x7", bus.Out, 32'h0000_0023);

    apply_check("neg1_sq",       16'hFFFF, 16'hFFFF, 32'h0000_0001);
    apply_check("min_sq",        16'h8000, 16'h8000, 32'h4000_0000);
    apply_check("min_x_max",     16'h8000, 16'h7FFF, 32'hC000_8000);
    apply_check("max_sq",        16'h7FFF, 16'h7FFF, 32'h3FFF_0001);
    apply_check("zero_x",        16'h0000, 16'h1234, 32'h0000_0000);
    apply_check("zero_y",        16'hABCD, 16'h0000, 32'h0000_0000);
    apply_check("one_x_m2",      16'h0001, 16'hFFFE, 32'hFFFF_FFFE);
    apply_check("min_x_one",     16'h8000, 16'h0001, 32'hFFFF_8000);
    apply_check("min_x_neg1",    16'h8000, 16'hFFFF, 32'h0000_8000);
    apply_check("three_x_m3",    16'h0003, 16'hFFFD, 32'hFFFF_FFF7);
    apply_check("x1234_x2",      16'h1234, 16'h0002, 32'h0000_2468);
    apply_check("x0100_x0100",   16'h0100, 16'h0100, 32'h0001_0000);

    // Back-to-back random stream with a reset pulse in the middle
    prev_valid = 1'b0;
    prev_exp   = '0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (prev_valid) check_eq("stream", bus.Out, prev_exp);
      if (k == 500) begin
        #1 rst = 1'b1;
        #1 check_eq("mid_reset_async", bus.Out, 32'h0000_0000);
        @(negedge clk);
        check_eq("mid_reset_hold", bus.Out, 32'h0000_0000);
        rst = 1'b0;
      end
      rx = 16'($urandom);
      ry = 16'($urandom);
      bus.X = rx;
      bus.Y = ry;
      prev_exp   = ref_prod(rx, ry);
      prev_valid = 1'b1;
    end
    @(negedge clk);
    check_eq("stream_last", bus.Out, prev_exp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
